// File: rtl/xillybus_hls_stream_bridge.sv
// ---------------------------------------------------------------------------
// xillybus_hls_stream_bridge
//
// Bridges one Xillybus host-to-FPGA pipe and one FPGA-to-host pipe to an HLS
// function with ap_fifo style ports, all on bus_clk.
//
// Handshakes:
//   host write : user_w_wren strobes user_w_data in; user_w_full means the
//                input memory is full (the word is dropped, err_overflow set).
//   HLS input  : in_r_dout is valid while in_r_empty_n=1; in_r_read consumes it.
//   HLS output : out_r_write strobes out_r_din in; only legal while
//                out_r_full_n=1.
//   host read  : user_r_rden while !user_r_empty loads user_r_data on the
//                next edge (non-FWFT).
//
// Ports:
//   bus_clk, bus_rst_n       clock, async active-low reset
//   user_w_*                 host write pipe (open/wren/data/full)
//   in_r_*                   ap_fifo read side presented to HLS
//   out_r_*                  ap_fifo write side accepted from HLS
//   ap_done                  HLS completion pulse, arms host EOF
//   user_r_*                 host read pipe (open/rden/data/empty/eof)
//   hls_rst                  active-high reset to HLS while either pipe closed
//   in_level, out_level      words held in each memory (prefetch excluded)
//   err_overflow             sticky, a host write was dropped
// ---------------------------------------------------------------------------
module xillybus_hls_stream_bridge #(
  parameter int DATA_W    = 32,
  parameter int IN_DEPTH  = 512,
  parameter int OUT_DEPTH = 512
) (
  input  logic                          bus_clk,
  input  logic                          bus_rst_n,
  input  logic                          user_w_open,
  input  logic                          user_w_wren,
  input  logic [DATA_W-1:0]             user_w_data,
  output logic                          user_w_full,
  output logic [DATA_W-1:0]             in_r_dout,
  output logic                          in_r_empty_n,
  input  logic                          in_r_read,
  input  logic [DATA_W-1:0]             out_r_din,
  input  logic                          out_r_write,
  output logic                          out_r_full_n,
  input  logic                          ap_done,
  input  logic                          user_r_open,
  input  logic                          user_r_rden,
  output logic [DATA_W-1:0]             user_r_data,
  output logic                          user_r_empty,
  output logic                          user_r_eof,
  output logic                          hls_rst,
  output logic [$clog2(IN_DEPTH):0]     in_level,
  output logic [$clog2(OUT_DEPTH):0]    out_level,
  output logic                          err_overflow
);

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);

  // Pointers carry one extra bit so full and empty are distinguishable.
  typedef logic [IN_AW:0]  in_ptr_t;
  typedef logic [OUT_AW:0] out_ptr_t;

  localparam in_ptr_t  IN_FULL  = in_ptr_t'(IN_DEPTH);
  localparam in_ptr_t  IN_ONE   = in_ptr_t'(1);
  localparam out_ptr_t OUT_FULL = out_ptr_t'(OUT_DEPTH);
  localparam out_ptr_t OUT_ONE  = out_ptr_t'(1);

  // -------------------------------------------------------------------------
  // Input FIFO + prefetch adapter
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] in_mem [IN_DEPTH];
  in_ptr_t           in_wr_q, in_wr_d;
  in_ptr_t           in_rd_q, in_rd_d;
  logic              in_vld_q, in_vld_d;
  logic [DATA_W-1:0] in_dout_q;
  logic              in_full;
  logic              in_fetch;
  logic              in_wr_en;
  logic              in_drop;

  assign in_level = in_wr_q - in_rd_q;
  assign in_full  = (in_level == IN_FULL);

  // Refill the output register whenever it is empty or being consumed.
  assign in_fetch = user_w_open && (in_level != '0) && (in_r_read || !in_vld_q);

  // A fetch in the same cycle frees a slot, so a full memory still accepts.
  assign in_wr_en = user_w_wren && user_w_open && (!in_full || in_fetch);
  assign in_drop  = user_w_wren && in_full && !in_fetch;

  always_comb begin
    in_wr_d  = in_wr_q;
    in_rd_d  = in_rd_q;
    in_vld_d = in_vld_q;
    if (!user_w_open) begin
      in_wr_d  = '0;
      in_rd_d  = '0;
      in_vld_d = 1'b0;
    end else begin
      if (in_wr_en) in_wr_d = in_wr_q + IN_ONE;
      if (in_fetch) begin
        in_rd_d  = in_rd_q + IN_ONE;
        in_vld_d = 1'b1;
      end else if (in_r_read) begin
        in_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge bus_clk) begin
    if (in_wr_en) in_mem[in_wr_q[IN_AW-1:0]] <= user_w_data;
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      in_wr_q   <= '0;
      in_rd_q   <= '0;
      in_vld_q  <= 1'b0;
      in_dout_q <= '0;
    end else begin
      in_wr_q  <= in_wr_d;
      in_rd_q  <= in_rd_d;
      in_vld_q <= in_vld_d;
      // Read and write to the same slot in one cycle returns the old word,
      // which is the head being fetched.
      if (in_fetch) in_dout_q <= in_mem[in_rd_q[IN_AW-1:0]];
    end
  end

  assign in_r_dout    = in_dout_q;
  assign in_r_empty_n = in_vld_q;
  assign user_w_full  = in_full;

  // -------------------------------------------------------------------------
  // Output FIFO
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] out_mem [OUT_DEPTH];
  out_ptr_t          out_wr_q, out_wr_d;
  out_ptr_t          out_rd_q, out_rd_d;
  logic [DATA_W-1:0] out_rdata_q;
  logic              out_full;
  logic              out_rd_en;
  logic              out_wr_en;
  logic              run_q;

  assign out_level = out_wr_q - out_rd_q;
  assign out_full  = (out_level == OUT_FULL);
  assign out_rd_en = user_r_rden && user_r_open && (out_level != '0);
  // With the read pipe closed, words are swallowed so HLS can never stall.
  assign out_wr_en = out_r_write && user_r_open && (!out_full || out_rd_en);

  always_comb begin
    out_wr_d = out_wr_q;
    out_rd_d = out_rd_q;
    if (!user_r_open) begin
      out_wr_d = '0;
      out_rd_d = '0;
    end else begin
      if (out_wr_en) out_wr_d = out_wr_q + OUT_ONE;
      if (out_rd_en) out_rd_d = out_rd_q + OUT_ONE;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (out_wr_en) out_mem[out_wr_q[OUT_AW-1:0]] <= out_r_din;
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      out_wr_q    <= '0;
      out_rd_q    <= '0;
      out_rdata_q <= '0;
    end else begin
      out_wr_q <= out_wr_d;
      out_rd_q <= out_rd_d;
      if (out_rd_en) out_rdata_q <= out_mem[out_rd_q[OUT_AW-1:0]];
    end
  end

  assign user_r_data  = out_rdata_q;
  assign user_r_empty = (out_level == '0);
  // run_q keeps full_n low while in reset and until the first clock after it.
  assign out_r_full_n = run_q && (!out_full || !user_r_open);

  // -------------------------------------------------------------------------
  // EOF state machine: arm on ap_done, fire once the output memory drains.
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    EOF_IDLE    = 2'd0,
    EOF_PENDING = 2'd1,
    EOF_DONE    = 2'd2
  } eof_state_t;

  eof_state_t eof_state_q;
  logic       eof_q;

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      eof_state_q <= EOF_IDLE;
      eof_q       <= 1'b0;
    end else if (!user_r_open) begin
      eof_state_q <= EOF_IDLE;
      eof_q       <= 1'b0;
    end else begin
      case (eof_state_q)
        EOF_IDLE: begin
          if (ap_done) eof_state_q <= EOF_PENDING;
        end
        EOF_PENDING: begin
          // A write in flight this cycle means the memory is not really empty.
          if ((out_level == '0) && !out_r_write) begin
            eof_state_q <= EOF_DONE;
            eof_q       <= 1'b1;
          end
        end
        EOF_DONE: begin
          eof_q <= 1'b1;
        end
        default: begin
          eof_state_q <= EOF_IDLE;
          eof_q       <= 1'b0;
        end
      endcase
    end
  end

  assign user_r_eof = eof_q;

  // -------------------------------------------------------------------------
  // HLS reset, overflow flag, start-up qualifier
  // -------------------------------------------------------------------------
  logic w_open_q;
  logic hls_rst_q;
  logic ovf_q;

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      w_open_q  <= 1'b0;
      hls_rst_q <= 1'b1;
      ovf_q     <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      w_open_q  <= user_w_open;
      hls_rst_q <= !(user_w_open && user_r_open);
      run_q     <= 1'b1;
      // A fresh open of the write pipe starts a new session with a clean flag.
      if (user_w_open && !w_open_q) ovf_q <= 1'b0;
      else if (in_drop)             ovf_q <= 1'b1;
    end
  end

  assign hls_rst      = hls_rst_q;
  assign err_overflow = ovf_q;

endmodule
